// File: rtl/soc_axi_pkg.sv
// Shared AXI definitions: response codes and the byte-strobe merge used by register banks.
package soc_axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Byte lane i of the result comes from new_val when strb[i] is set, else from old_val.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register array with byte-strobe writes, one-hot commit pulses and an asynchronous read mux.
module axi_lite_reg_bank
    import soc_axi_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          IDX_W       = 3,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDX_W-1:0]       widx,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    input  logic [IDX_W-1:0]       ridx,
    output logic [31:0]            rdata,
    output logic [NUM_REGS*32-1:0] reg_out,
    output logic [NUM_REGS-1:0]    reg_wr
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else if (we) begin
            regs[widx] <= strb_merge(regs[widx], wdata, wstrb);
        end
    end

    // Pulse marks the commit cycle, even when every strobe is clear.
    always_comb begin
        reg_wr = '0;
        if (we) reg_wr[widx] = 1'b1;
    end

    assign rdata = regs[ridx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS 32-bit registers exported as a flat bus.
// Define AXI_LITE_REG_DECERR_EN to answer DECERR outside the BASE_ADDR window.
module axi_lite_reg_slave
    import soc_axi_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [31:0]            awaddr,
    input  logic [2:0]             awprot,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [31:0]            araddr,
    input  logic [2:0]             arprot,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [1:0]             rresp,
    output logic [31:0]            rdata,
    output logic [NUM_REGS*32-1:0] reg_out,
    output logic [NUM_REGS-1:0]    reg_wr
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a source keeps valid and its payload stable until that edge, ready may change freely.
    logic             aw_held, w_held;
    logic [IDX_W-1:0] aw_idx;
    logic             aw_bad_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic             aw_hs, w_hs, ar_hs, commit;
    logic             aw_miss, ar_miss, aw_bad, ar_bad;
    logic [31:0]      bank_rdata;

    assign awready = !aw_held;
    assign wready  = !w_held;
    assign arready = !rvalid || rready;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_held && w_held && (!bvalid || bready);

    assign aw_miss = awaddr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2];
    assign ar_miss = araddr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2];

`ifdef AXI_LITE_REG_DECERR_EN
    assign aw_bad = aw_miss;
    assign ar_bad = ar_miss;
    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
`else
    // Every address aliases into the bank.
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0], aw_miss, ar_miss};
`endif

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            aw_bad_q <= 1'b0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            // A hold can only fill while empty and only drain while full, so these never collide.
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx   <= awaddr[IDX_W+1:2];
                aw_bad_q <= aw_bad;
            end else if (commit) begin
                aw_held  <= 1'b0;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end else if (commit) begin
                w_held   <= 1'b0;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= aw_bad_q ? RESP_DECERR : RESP_OKAY;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    // The bank read is combinational, so a same-cycle commit is not yet visible here.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= ar_bad ? RESP_DECERR : RESP_OKAY;
            rdata  <= ar_bad ? 32'h0 : bank_rdata;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    axi_lite_reg_bank #(
        .NUM_REGS    (NUM_REGS),
        .IDX_W       (IDX_W),
        .RESET_VALUE (RESET_VALUE)
    ) u_bank (
        .clk     (g_clk),
        .rst_n   (g_resetn),
        .we      (commit && !aw_bad_q),
        .widx    (aw_idx),
        .wdata   (w_data_q),
        .wstrb   (w_strb_q),
        .ridx    (araddr[IDX_W+1:2]),
        .rdata   (bank_rdata),
        .reg_out (reg_out),
        .reg_wr  (reg_wr)
    );

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: writes, B back-pressure, streaming reads, decode, reset.
module tb_axi_lite_reg_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic         g_clk, g_resetn;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  bexp_q[$];

    axi_lite_reg_slave dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
        .reg_out(reg_out), .reg_wr(reg_wr)
    );

    // Clock and watchdog
    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return reg_out[32*i +: 32];
    endfunction

    task automatic cyc();
        @(negedge g_clk);
    endtask

    // Drivers: called and returning at a falling edge.
    task automatic aw_send(input logic [31:0] a);
        logic hs;
        awvalid = 1'b1;
        awaddr  = a;
        for (int n = 0; n < 20; n++) begin
            hs = awready;
            cyc();
            if (hs) begin
                awvalid = 1'b0;
                break;
            end
        end
        if (awvalid) check("aw_timeout", 32'd0, 32'd1);
        awvalid = 1'b0;
    endtask

    task automatic wr_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic a_hs, w_hs;
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d; wstrb = s;
        for (int n = 0; n < 20; n++) begin
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            cyc();
            if (a_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            if (!awvalid && !wvalid) break;
        end
        if (awvalid || wvalid) check("wr_timeout", 32'd0, 32'd1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic b_take();
        logic found;
        found  = 1'b0;
        bready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bvalid) begin
                check("bresp", 32'(bresp), 32'(bexp_q.pop_front()));
                found = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        bready = 1'b0;
        if (!found) check("b_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        g_resetn = 1'b0;
        awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; arprot = 0; rready = 0;
        repeat (3) cyc();
        #1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_reg_out", 32'(reg_out != '0), 32'd0);
        cyc();
        g_resetn = 1'b1;
        cyc();

        // 1: AW and W together
        bexp_q.push_back(2'b00);
        wr_both(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("t1_reg_wr", 32'(reg_wr), 32'h04);
        check("t1_bvalid_early", 32'(bvalid), 32'd0);
        check("t1_awready_held", 32'(awready), 32'd0);
        cyc(); #1;
        check("t1_bvalid", 32'(bvalid), 32'd1);
        check("t1_reg_wr_off", 32'(reg_wr), 32'd0);
        check("t1_reg2", reg_at(2), 32'hDEAD_BEEF);
        check("t1_awready_free", 32'(awready), 32'd1);
        b_take();

        // 2: W three cycles ahead of AW, single byte strobe
        wvalid = 1'b1; wdata = 32'h0000_AB00; wstrb = 4'b0010;
        cyc();
        wvalid = 1'b0;
        #1;
        check("t2_wready_held", 32'(wready), 32'd0);
        cyc(); cyc(); #1;
        check("t2_wready_still", 32'(wready), 32'd0);
        check("t2_no_commit", 32'(reg_wr), 32'd0);
        bexp_q.push_back(2'b00);
        aw_send(BASE + 32'h4);
        #1;
        check("t2_reg_wr", 32'(reg_wr), 32'h02);
        b_take();
        check("t2_reg1", reg_at(1), 32'h0000_AB00);

        // 3: B back-pressure stalls the second commit
        bexp_q.push_back(2'b00);
        bexp_q.push_back(2'b00);
        wr_both(BASE + 32'hC, 32'h1111_2222, 4'hF);
        cyc();
        wr_both(BASE + 32'h10, 32'h3333_4444, 4'hF);
        #1;
        check("t3_awready_full", 32'(awready), 32'd0);
        check("t3_wready_full", 32'(wready), 32'd0);
        check("t3_stall", 32'(reg_wr), 32'd0);
        repeat (3) cyc();
        #1;
        check("t3_bvalid_hold", 32'(bvalid), 32'd1);
        check("t3_bresp_hold", 32'(bresp), 32'd0);
        check("t3_reg4_wait", reg_at(4), 32'd0);
        bready = 1'b1;
        #1;
        check("t3_reg_wr", 32'(reg_wr), 32'h10);
        check("t3_bresp1", 32'(bresp), 32'(bexp_q.pop_front()));
        cyc(); #1;
        check("t3_bvalid2", 32'(bvalid), 32'd1);
        check("t3_bresp2", 32'(bresp), 32'(bexp_q.pop_front()));
        check("t3_reg4", reg_at(4), 32'h3333_4444);
        check("t3_reg3", reg_at(3), 32'h1111_2222);
        cyc(); #1;
        check("t3_bvalid_done", 32'(bvalid), 32'd0);
        bready = 1'b0;

        // 4: fill remaining registers, including wstrb=0, then stream reads
        bexp_q.push_back(2'b00);
        wr_both(BASE + 32'h14, 32'hAABB_CCDD, 4'b1001);
        b_take();
        bexp_q.push_back(2'b00);
        wr_both(BASE + 32'h18, 32'hFFFF_FFFF, 4'b0000);
        #1;
        check("t4_strb0_pulse", 32'(reg_wr), 32'h40);
        b_take();
        bexp_q.push_back(2'b00);
        wr_both(BASE + 32'h1C, 32'h1234_5678, 4'hF);
        b_take();
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_AB00);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'h1111_2222);
        exp_q.push_back(32'h3333_4444);
        exp_q.push_back(32'hAA00_00DD);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h1234_5678);
        rready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                arvalid = 1'b1;
                araddr  = BASE + 32'(k * 4);
            end else begin
                arvalid = 1'b0;
            end
            #1;
            if (k < 8) check("t4_arready", 32'(arready), 32'd1);
            if (k > 0) begin
                check("t4_rvalid", 32'(rvalid), 32'd1);
                check("t4_rdata", rdata, exp_q.pop_front());
                check("t4_rresp", 32'(rresp), 32'd0);
            end
            cyc();
        end
        #1;
        check("t4_rvalid_idle", 32'(rvalid), 32'd0);

        // Read and write of reg0 in the same cycle returns the old value
        bexp_q.push_back(2'b00);
        wr_both(BASE, 32'h0000_0055, 4'hF);
        arvalid = 1'b1; araddr = BASE;
        cyc();
        arvalid = 1'b0;
        #1;
        check("t4_rw_rdata", rdata, 32'h0000_0000);
        check("t4_rw_reg0", reg_at(0), 32'h0000_0055);
        b_take();

        // 5: address outside the window
`ifdef AXI_LITE_REG_DECERR_EN
        bexp_q.push_back(2'b11);
`else
        bexp_q.push_back(2'b00);
`endif
        wr_both(32'h5000_0000, 32'h0BAD_F00D, 4'hF);
        #1;
`ifdef AXI_LITE_REG_DECERR_EN
        check("t5_reg_wr", 32'(reg_wr), 32'h00);
`else
        check("t5_reg_wr", 32'(reg_wr), 32'h01);
`endif
        b_take();
        arvalid = 1'b1; araddr = 32'h5000_0000;
        cyc();
        arvalid = 1'b0;
        #1;
        check("t5_rvalid", 32'(rvalid), 32'd1);
`ifdef AXI_LITE_REG_DECERR_EN
        check("t5_reg0", reg_at(0), 32'h0000_0055);
        check("t5_rresp", 32'(rresp), 32'd3);
        check("t5_rdata", rdata, 32'd0);
`else
        check("t5_reg0", reg_at(0), 32'h0BAD_F00D);
        check("t5_rresp", 32'(rresp), 32'd0);
        check("t5_rdata", rdata, 32'h0BAD_F00D);
`endif
        cyc();
        rready = 1'b0;

        // 6: reset with AW held and W pending
        aw_send(BASE + 32'h14);
        #1;
        check("t6_aw_held", 32'(awready), 32'd0);
        g_resetn = 1'b0;
        #1;
        check("t6_awready", 32'(awready), 32'd1);
        check("t6_bvalid", 32'(bvalid), 32'd0);
        check("t6_reg2", reg_at(2), 32'd0);
        check("t6_reg7", reg_at(7), 32'd0);
        cyc();
        g_resetn = 1'b1;
        cyc();
        wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'hF;
        cyc();
        wvalid = 1'b0;
        #1;
        check("t6_no_stale_aw", 32'(reg_wr), 32'd0);
        cyc(); #1;
        check("t6_no_b", 32'(bvalid), 32'd0);
        bexp_q.push_back(2'b00);
        aw_send(BASE + 32'h8);
        #1;
        check("t6_reg_wr", 32'(reg_wr), 32'h04);
        b_take();
        check("t6_reg2_new", reg_at(2), 32'hCAFE_0001);
        check("t6_reg5", reg_at(5), 32'd0);

        check("rq_empty", 32'(exp_q.size()), 32'd0);
        check("bq_empty", 32'(bexp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
